// File: rtl/mips_alu_muldiv_seq_if.sv
// Function codes and the valid/ready request interface of the HI/LO multiply/divide sequencer.
package mips_alu_muldiv_seq_pkg;
  localparam int unsigned FUNC_W = 4;

  // Codes above FUNC_MFLO belong to other execute-stage units and are ignored here.
  typedef enum logic [FUNC_W-1:0] {
    FUNC_MULU = 4'd0,
    FUNC_MULS = 4'd1,
    FUNC_DIVU = 4'd2,
    FUNC_DIVS = 4'd3,
    FUNC_MTHI = 4'd4,
    FUNC_MTLO = 4'd5,
    FUNC_MFHI = 4'd6,
    FUNC_MFLO = 4'd7
  } mips_alu_func_t;
endpackage

interface mips_alu_muldiv_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                                           req_valid;
  logic                                           req_ready;
  logic [mips_alu_muldiv_seq_pkg::FUNC_W-1:0]     func;
  logic [DATA_W-1:0]                              data1;
  logic [DATA_W-1:0]                              data2;
  logic [DATA_W-1:0]                              result;

  modport master (
    output req_valid, func, data1, data2,
    input  req_ready, result
  );

  modport slave (
    input  req_valid, func, data1, data2,
    output req_ready, result
  );
endinterface

// File: rtl/mips_alu_muldiv_seq.sv
// Iterative shift-add multiply / restoring divide sequencer owning HI/LO.
// Define MIPS_ALU_MULDIV_SEQ_EARLY_OUT_EN to end multiplies once the remaining multiplier is zero.
module mips_alu_muldiv_seq
  import mips_alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  mips_alu_muldiv_seq_if.slave req,
  output logic [DATA_W-1:0]    hi,
  output logic [DATA_W-1:0]    lo,
  output logic                 busy,
  output logic                 div_zero
);

`ifdef MIPS_ALU_MULDIV_SEQ_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     opb_q, opb_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  div_zero_q, div_zero_d;
  logic                  is_div_q, is_div_d;
  logic                  sgn_lo_q, sgn_lo_d;
  logic                  sgn_hi_q, sgn_hi_d;

  logic                  ready;
  logic                  accept;
  logic                  op_mul, op_div, op_signed;
  logic [DATA_W-1:0]     mag1, mag2;
  logic [2*DATA_W-1:0]   mul_acc_nxt, div_acc_nxt, prod_fix;
  logic [DATA_W-1:0]     mul_opb_nxt, quo_fix, rem_fix, rem_sub;
  logic [DATA_W:0]       partial;
  logic                  fits;

  assign ready  = reset_n && (state_q == ST_IDLE) && !flush;
  assign accept = req.req_valid && ready;

  always_comb begin
    op_mul    = (req.func == FUNC_MULU) || (req.func == FUNC_MULS);
    op_div    = (req.func == FUNC_DIVU) || (req.func == FUNC_DIVS);
    op_signed = (req.func == FUNC_MULS) || (req.func == FUNC_DIVS);
    mag1      = (op_signed && req.data1[DATA_W-1]) ? -req.data1 : req.data1;
    mag2      = (op_signed && req.data2[DATA_W-1]) ? -req.data2 : req.data2;
  end

  // acc holds the running product, or {remainder, dividend/quotient} while dividing.
  always_comb begin
    mul_acc_nxt = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_opb_nxt = opb_q >> 1;
    partial     = acc_q[2*DATA_W-1:DATA_W-1];
    fits        = partial >= {1'b0, opb_q};
    rem_sub     = partial[DATA_W-1:0] - opb_q;
    div_acc_nxt = {fits ? rem_sub : partial[DATA_W-1:0], acc_q[DATA_W-2:0], fits};
    prod_fix    = sgn_lo_q ? -acc_q : acc_q;
    quo_fix     = sgn_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix     = sgn_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      sgn_lo_q   <= 1'b0;
      sgn_hi_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
      is_div_q   <= is_div_d;
      sgn_lo_q   <= sgn_lo_d;
      sgn_hi_q   <= sgn_hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (op_mul || op_div)) begin
          state_d = (EarlyOut && op_mul && (mag2 == '0)) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if ((cnt_q == LastCnt) || (EarlyOut && !is_div_q && (mul_opb_nxt == '0))) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    is_div_d   = is_div_q;
    sgn_lo_d   = sgn_lo_q;
    sgn_hi_d   = sgn_hi_q;
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_mul || op_div) begin
            cnt_d    = '0;
            is_div_d = op_div;
            sgn_lo_d = op_signed && (req.data1[DATA_W-1] ^ req.data2[DATA_W-1]);
            sgn_hi_d = op_signed && op_div && req.data1[DATA_W-1];
            opb_d    = mag2;
            mcand_d  = {{DATA_W{1'b0}}, mag1};
            acc_d    = op_div ? {{DATA_W{1'b0}}, mag1} : '0;
          end else if (req.func == FUNC_MTHI) begin
            hi_d = req.data1;
          end else if (req.func == FUNC_MTLO) begin
            lo_d = req.data1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = div_acc_nxt;
        end else begin
          acc_d   = mul_acc_nxt;
          mcand_d = mcand_q << 1;
          opb_d   = mul_opb_nxt;
        end
      end
      ST_FIX: begin
        if (!flush) begin
          if (is_div_q) begin
            // A zero divisor leaves the sign-restored remainder equal to data1, so only LO needs forcing.
            hi_d       = rem_fix;
            lo_d       = (opb_q == '0) ? '1 : quo_fix;
            div_zero_d = (opb_q == '0);
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req.req_ready = ready;
    req.result    = '0;
    if (accept && (req.func == FUNC_MFHI)) begin
      req.result = hi_q;
    end else if (accept && (req.func == FUNC_MFLO)) begin
      req.result = lo_q;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mips_alu_muldiv_seq.sv
// Bench for mips_alu_muldiv_seq: directed vector table, multi-cycle corner sequences, random ops vs. an arithmetic model.
module tb_mips_alu_muldiv_seq;
  import mips_alu_muldiv_seq_pkg::*;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [W-1:0]  hi, lo;
  logic          busy, div_zero;

  mips_alu_muldiv_seq_if #(.DATA_W(W)) bus ();

  mips_alu_muldiv_seq #(.DATA_W(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .req      (bus.slave),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edz;
  } vec_t;

  vec_t vecs [12];

  task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Architectural effect of one completed operation, straight from the arithmetic rules.
  task automatic model_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    case (f)
      FUNC_MULU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      FUNC_MULS: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      FUNC_DIVU, FUNC_DIVS: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = '1;
          m_dz = 1'b1;
        end else begin
          m_dz = 1'b0;
          if (f == FUNC_DIVU) begin
            m_lo = a / b;
            m_hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = a;
            m_hi = '0;
          end else begin
            sa = $signed(a);
            sb = $signed(b);
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
      end
      FUNC_MTHI: m_hi = a;
      FUNC_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Number of cycles req_ready stays low after the accept edge.
  function automatic int unsigned exp_lat(input logic [3:0] f, input logic [W-1:0] b);
`ifdef MIPS_ALU_MULDIV_SEQ_EARLY_OUT_EN
    logic [W-1:0] m;
    int unsigned  n;
    if (f == FUNC_MULU || f == FUNC_MULS) begin
      m = (f == FUNC_MULS && b[W-1]) ? -b : b;
      n = 0;
      while (m != 0) begin
        m = m >> 1;
        n++;
      end
      return n + 1;
    end
`endif
    return W + 1;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic do_muldiv(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] old_hi, old_lo;
    int unsigned  lat, el;
    old_hi = m_hi;
    old_lo = m_lo;
    el     = exp_lat(f, b);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = f;
    bus.data1     = a;
    bus.data2     = b;
    #1;
    check1("accept_ready", bus.req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check1("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (bus.req_ready !== 1'b1 && lat < 200) begin
      lat++;
      if (lat == el) begin
        check32("hi_hold", hi, old_hi);
        check32("lo_hold", lo, old_lo);
      end
      @(negedge clock);
    end
    model_op(f, a, b);
    check32("latency", lat, el);
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
    check1("div_zero", div_zero, m_dz);
    check1("busy_done", busy, 1'b0);
  endtask

  task automatic do_move(input logic [3:0] f, input logic [W-1:0] a);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = f;
    bus.data1     = a;
    #1;
    check1("move_ready", bus.req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    model_op(f, a, '0);
    check32("move_hi", hi, m_hi);
    check32("move_lo", lo, m_lo);
  endtask

  task automatic do_read(input logic [3:0] f);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = f;
    bus.data1     = $urandom();
    #1;
    check32((f == FUNC_MFHI) ? "mfhi" : "mflo", bus.result, (f == FUNC_MFHI) ? m_hi : m_lo);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned el, n;
    logic [W-1:0] old_hi, old_lo;
    logic         old_dz;

    vecs[0]  = '{FUNC_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{FUNC_MULS, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{FUNC_DIVS, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{FUNC_DIVU, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{FUNC_MULU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{FUNC_DIVU, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 1'b0};
    vecs[6]  = '{FUNC_MULU, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 32'h0000_0015, 1'b0};
    vecs[7]  = '{FUNC_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{FUNC_DIVS, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{FUNC_MULS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{FUNC_DIVS, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{FUNC_MULS, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};

    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.func      = FUNC_MULU;
    bus.data1     = '0;
    bus.data2     = '0;

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    check1("rst_ready_low", bus.req_ready, 1'b0);
    check32("rst_hi", hi, '0);
    check32("rst_lo", lo, '0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_div_zero", div_zero, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check1("rst_release_ready", bus.req_ready, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      do_muldiv(vecs[i].f, vecs[i].a, vecs[i].b);
      check32("tbl_hi", hi, vecs[i].ehi);
      check32("tbl_lo", lo, vecs[i].elo);
      check1("tbl_div_zero", div_zero, vecs[i].edz);
    end

    // Mthi then Mfhi on the very next cycle.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = FUNC_MTHI;
    bus.data1     = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    model_op(FUNC_MTHI, 32'h1234_5678, '0);
    bus.func  = FUNC_MFHI;
    bus.data1 = 32'hDEAD_0000;
    #1;
    check32("mthi_mfhi_bypass", bus.result, 32'h1234_5678);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    #1;
    check32("result_idle", bus.result, '0);
    do_move(FUNC_MTLO, 32'hCAFE_F00D);
    do_read(FUNC_MFLO);

    // Unrelated function code: accepted, result 0, HI/LO untouched.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = 4'd9;
    bus.data1     = 32'h5555_AAAA;
    #1;
    check1("other_ready", bus.req_ready, 1'b1);
    check32("other_result", bus.result, '0);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check32("other_hi", hi, m_hi);
    check32("other_lo", lo, m_lo);

    // Mfhi held valid while a multiply is in flight.
    el = exp_lat(FUNC_MULU, 32'h0000_0100);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = FUNC_MULU;
    bus.data1     = 32'h1234_5678;
    bus.data2     = 32'h0000_0100;
    @(posedge clock);
    @(negedge clock);
    bus.func = FUNC_MFHI;
    #1;
    check32("mfhi_stalled_result", bus.result, '0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
      #1;
    end
    model_op(FUNC_MULU, 32'h1234_5678, 32'h0000_0100);
    check32("mfhi_stall_cycles", n, el);
    check32("mfhi_after_busy", bus.result, 32'h0000_0012);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;

    // Flush mid-divide: back to IDLE, HI/LO and div_zero untouched.
    old_hi = m_hi;
    old_lo = m_lo;
    old_dz = m_dz;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = FUNC_DIVU;
    bus.data1     = 32'h0000_0064;
    bus.data2     = 32'h0000_0000;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clock);
    flush = 1'b1;
    #1;
    check1("flush_run_ready_low", bus.req_ready, 1'b0);
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check1("flush_run_busy", busy, 1'b0);
    check1("flush_run_ready", bus.req_ready, 1'b1);
    check32("flush_run_hi", hi, old_hi);
    check32("flush_run_lo", lo, old_lo);
    check1("flush_run_div_zero", div_zero, old_dz);

    // Flush in IDLE blocks acceptance.
    @(negedge clock);
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.func      = FUNC_MTHI;
    bus.data1     = 32'h0BAD_0BAD;
    #1;
    check1("flush_idle_ready", bus.req_ready, 1'b0);
    @(posedge clock);
    @(negedge clock);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    check32("flush_idle_hi", hi, old_hi);

    // Flush on the same edge as FIX: no write.
    el = exp_lat(FUNC_MULU, 32'h0000_0006);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = FUNC_MULU;
    bus.data1     = 32'h0000_0005;
    bus.data2     = 32'h0000_0006;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (el - 1) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check32("flush_fix_hi", hi, old_hi);
    check32("flush_fix_lo", lo, old_lo);
    check1("flush_fix_busy", busy, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: do_muldiv(4'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
        5:             do_move(($urandom_range(0, 1) == 0) ? FUNC_MTHI : FUNC_MTLO, $urandom());
        default:       do_read(($urandom_range(0, 1) == 0) ? FUNC_MFHI : FUNC_MFLO);
      endcase
    end

    // Reset asserted mid-RUN.
    do_move(FUNC_MTHI, 32'hDEAD_BEEF);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.func      = FUNC_MULU;
    bus.data1     = 32'hFFFF_FFFF;
    bus.data2     = 32'hFFFF_FFFF;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check32("midrun_rst_hi", hi, '0);
    check32("midrun_rst_lo", lo, '0);
    check1("midrun_rst_busy", busy, 1'b0);
    check1("midrun_rst_ready", bus.req_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    #1;
    check1("midrun_release_ready", bus.req_ready, 1'b1);
    do_muldiv(FUNC_DIVU, 32'h0000_0009, 32'h0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
